vcfg_unit: RTL and testbench
============================

# vcfg_unit

Parametrised vector configuration unit for the vector coprocessor. It executes `vsetvli`, `vsetivli` and `vsetvl` through a valid/ready request interface and computes VLMAX and the new vl from AVL and vtype. It holds the architectural `vl`, `vtype` (with vill), `vstart` and a constant `vlenb`, and returns the new vl to the scalar core's `rd` through a writeback port. It sits between the instruction decoder and the vector lanes, which read its CSR outputs.

## Interface
- `VLEN`, 128: vector register length in bits (power of 2, ≥ `ELEN`).
- `ELEN`, 32: maximum element width in bits (32 or 64).
- `XLEN`, 32: scalar register width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  reset nrst, synchronous, active-low.
- `cfg_valid`  in  1  configuration request valid.
- `cfg_ready`  out  1  unit can accept a request.
- `cfg_mode`  in  2  0 = vsetvli, 1 = vsetivli, 2 = vsetvl, 3 = reserved (treated as vill).
- `cfg_avl`  in  XLEN  rs1 value, or zero-extended uimm[4:0] for vsetivli.
- `cfg_vtype`  in  XLEN  zimm or rs2 value.
- `cfg_rs1_x0`, `cfg_rd_x0`  in  1 each  rs1 / rd field is x0.
- `cfg_rd_idx`  in  5  destination register index.
- `wb_valid`  out  1  one-cycle pulse: write `wb_data` to `wb_rd`.
- `wb_rd`  out  5  writeback register index.
- `wb_data`  out  XLEN  new vl.
- `vstart_wr_en`  in  1  write vstart.
- `vstart_in`  in  XLEN  vstart write data.
- `vstart_clr`  in  1  vector instruction completed; clears vstart.
- `vl_out`, `vtype_out`, `vstart_out`, `vlenb_out`  out  XLEN each  CSR values.

## Operation
- vtype fields: vlmul[2:0], vsew[5:3], vta[6], vma[7], vill[XLEN-1]. Bits [XLEN-2:8] are reserved.
- vtype is illegal if any of the following holds:
  - vsew > log2(ELEN/8);
  - vlmul = 4;
  - reserved bits ≠ 0;
  - vlmul is fractional (5, 6, 7 = 1/8, 1/4, 1/2) and SEW > ELEN·LMUL;
  - mode = 3.
- VLMAX = (VLEN >> (vsew+3)), then shifted left by vlmul for vlmul 0–3, or right by (8−vlmul) for vlmul 5–7. Width is $clog2(VLEN)+1 bits, zero-extended to XLEN.
- AVL selection:
  - vsetivli: AVL = uimm.
  - rs1 ≠ x0: AVL = cfg_avl.
  - rs1 = x0, rd ≠ x0: AVL = all-ones.
  - rs1 = x0, rd = x0: AVL = current vl, so vl = min(old vl, VLMAX).
- Legal vtype: new vl = min(AVL, VLMAX); vtype_out = {0, vma, vta, vsew, vlmul}.
- Illegal vtype: vl = 0, vtype_out = 1<<(XLEN−1).
- Writeback is suppressed when rd = x0.
- FSM states:
  - IDLE: cfg_ready = 1. Handshake cfg_valid & cfg_ready captures the request into a stage register and moves to EXEC.
  - EXEC: cfg_ready = 0. Compute, commit the CSRs, pulse wb, clear vstart, return to IDLE.
- vstart priority, highest first:
  1. vstart_wr_en;
  2. config commit or vstart_clr (either clears).
- `vlenb_out` = VLEN/8, constant.

## Timing
- Reset values:
  - vl = 0, vtype = 1<<(XLEN−1) (vill set), vstart = 0;
  - wb_valid = 0, wb_rd = 0, wb_data = 0;
  - FSM in IDLE, cfg_ready = 1.
- Accept at edge E0. At E1, the CSRs update and wb_valid goes high for exactly the cycle after E1.
- cfg_ready is low for the cycle after E0. Maximum throughput is one request per 2 cycles.
- A request held valid across EXEC is accepted on the edge after commit, and sees the committed vl.
- Reset asserted during EXEC: the pending request is dropped, no wb pulse is issued, and all CSRs take reset values.
- cfg inputs are sampled only on the handshake edge and may change afterwards.

## Structure
- `vcfg_pkg` holds:
  - the cfg_mode enum;
  - vtype field bit positions and the vill position;
  - vlmul encodings;
  - the vtype reset constant.
- Sub-module `vcfg_vlmax_calc` is combinational: vtype → {legal, VLMAX}, parametrised by VLEN and ELEN.
- `vcfg_unit` contains the FSM, the request stage register, the AVL mux/min logic, the CSR registers and the writeback register.

## Test plan
All scenarios use VLEN = 128, ELEN = 32, XLEN = 32.
1. vsetvli, avl = 10, vtype = 0x010 (SEW32, LMUL1), rd = x5 -> vl = 4, vtype_out = 0x010, wb_valid pulse on the cycle after E1 with wb_rd = 5, wb_data = 4.
2. vsetivli, uimm = 3, vtype = 0x001 (SEW8, LMUL2) -> VLMAX = 32, vl = 3.
3. vsetvl, rs1 = x0, rd = x1, vtype = 0x00F (SEW16, LMUL1/2) -> vl = 4; then rs1 = x0, rd = x0, vtype = 0x000 -> vl remains 4, no wb pulse.
4. Illegal vtypes 0x018 (SEW64), 0x004 (vlmul 4), 0x015 (SEW32, LMUL1/8), 0x100 (reserved bit) -> vl = 0, vtype_out = 0x8000_0000 for each.
5. cfg_valid held for 4 cycles with two different requests -> cfg_ready pattern 1, 0, 1, 0; two wb pulses in order; the second commit sees the first vl.
6. vstart_wr_en with vstart_in = 7 -> vstart = 7. Then vstart_wr_en (vstart_in = 9) in the same cycle as a commit -> vstart = 9. Then vstart_clr -> vstart = 0. Then nrst low during EXEC -> no wb pulse, vl = 0, vtype = 0x8000_0000.

Source files
------------

// File: rtl/vcfg_pkg.sv
// Shared types and constants for the vector configuration unit:
// cfg_mode encoding, vtype field layout, vlmul encodings and the vtype reset value.
package vcfg_pkg;

  typedef enum logic [1:0] {
    MODE_VSETVLI  = 2'd0,
    MODE_VSETIVLI = 2'd1,
    MODE_VSETVL   = 2'd2,
    MODE_RSVD     = 2'd3
  } cfg_mode_e;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } vlmul_e;

  localparam int VLMUL_LSB = 0;
  localparam int VSEW_LSB  = 3;
  localparam int VTA_POS   = 6;
  localparam int VMA_POS   = 7;
  localparam int RSVD_LSB  = 8;

  // vill always lives in the MSB of the XLEN-wide vtype CSR
  function automatic int vill_pos(input int xlen);
    return xlen - 1;
  endfunction

  // Reset / illegal vtype: only vill set; callers truncate to XLEN
  function automatic logic [63:0] vtype_rst(input int xlen);
    return 64'd1 << vill_pos(xlen);
  endfunction

endpackage

// File: rtl/vcfg_vlmax_calc.sv
// Combinational vtype decode: legality of (vsew, vlmul) against ELEN and the
// resulting VLMAX for a VLEN-bit register group.
module vcfg_vlmax_calc
  import vcfg_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32
) (
  input  logic [2:0]             vlmul,
  input  logic [2:0]             vsew,
  output logic                   legal,
  output logic [$clog2(VLEN):0]  vlmax
);

  localparam int VW = $clog2(VLEN) + 1;
  localparam logic [2:0] SEW_MAX = 3'($clog2(ELEN / 8));

  logic [VW-1:0] base_s;
  logic [31:0]   sew_bits_s;
  logic [31:0]   elen_frac_s;
  logic [3:0]    frac_sh_s;
  logic          lmul_bad_s;

  // VLMAX scaling and the SEW <= ELEN*LMUL check for fractional groups
  always_comb begin
    frac_sh_s   = 4'd8 - {1'b0, vlmul};
    base_s      = VW'(VLEN) >> ({1'b0, vsew} + 4'd3);
    sew_bits_s  = 32'd8 << vsew;
    elen_frac_s = 32'(ELEN) >> frac_sh_s;
    lmul_bad_s  = 1'b0;
    vlmax       = base_s;
    case (vlmul_e'(vlmul))
      LMUL_1, LMUL_2, LMUL_4, LMUL_8: begin
        vlmax = base_s << vlmul[1:0];
      end
      LMUL_F8, LMUL_F4, LMUL_F2: begin
        vlmax      = base_s >> frac_sh_s;
        lmul_bad_s = (sew_bits_s > elen_frac_s);
      end
      LMUL_RSVD: begin
        vlmax      = {VW{1'b0}};
        lmul_bad_s = 1'b1;
      end
      default: begin
        vlmax      = {VW{1'b0}};
        lmul_bad_s = 1'b1;
      end
    endcase
    legal = (vsew <= SEW_MAX) && !lmul_bad_s;
  end

endmodule

// File: rtl/vcfg_unit.sv
// Vector configuration unit: executes vsetvli/vsetivli/vsetvl in two cycles,
// owns vl/vtype/vstart/vlenb and writes the new vl back to the scalar rd.
module vcfg_unit
  import vcfg_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [1:0]      cfg_mode,
  input  logic [XLEN-1:0] cfg_avl,
  input  logic [XLEN-1:0] cfg_vtype,
  input  logic            cfg_rs1_x0,
  input  logic            cfg_rd_x0,
  input  logic [4:0]      cfg_rd_idx,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            vstart_wr_en,
  input  logic [XLEN-1:0] vstart_in,
  input  logic            vstart_clr,
  output logic [XLEN-1:0] vl_out,
  output logic [XLEN-1:0] vtype_out,
  output logic [XLEN-1:0] vstart_out,
  output logic [XLEN-1:0] vlenb_out
);

  localparam int VW = $clog2(VLEN) + 1;
  localparam logic [XLEN-1:0] VTYPE_RST = XLEN'(vtype_rst(XLEN));

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  state_e          state_r;
  logic            cfg_ready_r;
  cfg_mode_e       req_mode_r;
  logic [XLEN-1:0] req_avl_r;
  logic [XLEN-2:0] req_vtype_r;
  logic            req_rs1_x0_r;
  logic            req_rd_x0_r;
  logic [4:0]      req_rd_idx_r;
  logic [XLEN-1:0] vl_r;
  logic [XLEN-1:0] vtype_r;
  logic [XLEN-1:0] vstart_r;
  logic            wb_valid_r;
  logic [4:0]      wb_rd_r;
  logic [XLEN-1:0] wb_data_r;

  logic            calc_legal_s;
  logic [VW-1:0]   calc_vlmax_s;
  logic            legal_s;
  logic [XLEN-1:0] avl_s;
  logic [XLEN-1:0] vlmax_s;
  logic [XLEN-1:0] new_vl_s;
  logic [XLEN-1:0] new_vtype_s;

  // The incoming vill bit carries no meaning for the request; legality is re-derived
  logic unused_vill_s;
  assign unused_vill_s = cfg_vtype[XLEN-1];

  vcfg_vlmax_calc #(
    .VLEN (VLEN),
    .ELEN (ELEN)
  ) u_vlmax_calc (
    .vlmul (req_vtype_r[VLMUL_LSB +: 3]),
    .vsew  (req_vtype_r[VSEW_LSB +: 3]),
    .legal (calc_legal_s),
    .vlmax (calc_vlmax_s)
  );

  // AVL selection and new vl / vtype for the staged request
  always_comb begin
    vlmax_s = {{(XLEN-VW){1'b0}}, calc_vlmax_s};
    legal_s = calc_legal_s && !(|req_vtype_r[XLEN-2:RSVD_LSB]) && (req_mode_r != MODE_RSVD);
    if (req_mode_r == MODE_VSETIVLI) begin
      avl_s = req_avl_r;
    end else if (!req_rs1_x0_r) begin
      avl_s = req_avl_r;
    end else if (!req_rd_x0_r) begin
      avl_s = {XLEN{1'b1}};
    end else begin
      avl_s = vl_r;
    end
    if (legal_s) begin
      new_vl_s    = (avl_s < vlmax_s) ? avl_s : vlmax_s;
      new_vtype_s = {{(XLEN-8){1'b0}}, req_vtype_r[VMA_POS:VLMUL_LSB]};
    end else begin
      new_vl_s    = {XLEN{1'b0}};
      new_vtype_s = VTYPE_RST;
    end
  end

  // Request FSM, stage register, vl/vtype CSRs and writeback register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r      <= ST_IDLE;
      cfg_ready_r  <= 1'b1;
      req_mode_r   <= MODE_VSETVLI;
      req_avl_r    <= {XLEN{1'b0}};
      req_vtype_r  <= {(XLEN-1){1'b0}};
      req_rs1_x0_r <= 1'b0;
      req_rd_x0_r  <= 1'b0;
      req_rd_idx_r <= 5'd0;
      vl_r         <= {XLEN{1'b0}};
      vtype_r      <= VTYPE_RST;
      wb_valid_r   <= 1'b0;
      wb_rd_r      <= 5'd0;
      wb_data_r    <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          wb_valid_r <= 1'b0;
          if (cfg_valid && cfg_ready_r) begin
            req_mode_r   <= cfg_mode_e'(cfg_mode);
            req_avl_r    <= cfg_avl;
            req_vtype_r  <= cfg_vtype[XLEN-2:0];
            req_rs1_x0_r <= cfg_rs1_x0;
            req_rd_x0_r  <= cfg_rd_x0;
            req_rd_idx_r <= cfg_rd_idx;
            state_r      <= ST_EXEC;
            cfg_ready_r  <= 1'b0;
          end else begin
            state_r     <= ST_IDLE;
            cfg_ready_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          vl_r       <= new_vl_s;
          vtype_r    <= new_vtype_s;
          wb_valid_r <= !req_rd_x0_r;
          if (!req_rd_x0_r) begin
            wb_rd_r   <= req_rd_idx_r;
            wb_data_r <= new_vl_s;
          end else begin
            wb_rd_r   <= wb_rd_r;
            wb_data_r <= wb_data_r;
          end
          state_r     <= ST_IDLE;
          cfg_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          cfg_ready_r <= 1'b1;
          wb_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  // vstart: explicit write beats the clear from a commit or a completed instruction
  always_ff @(posedge clk) begin
    if (!nrst) begin
      vstart_r <= {XLEN{1'b0}};
    end else if (vstart_wr_en) begin
      vstart_r <= vstart_in;
    end else if ((state_r == ST_EXEC) || vstart_clr) begin
      vstart_r <= {XLEN{1'b0}};
    end else begin
      vstart_r <= vstart_r;
    end
  end

  assign cfg_ready  = cfg_ready_r;
  assign wb_valid   = wb_valid_r;
  assign wb_rd      = wb_rd_r;
  assign wb_data    = wb_data_r;
  assign vl_out     = vl_r;
  assign vtype_out  = vtype_r;
  assign vstart_out = vstart_r;
  assign vlenb_out  = XLEN'(VLEN / 8);

endmodule

// File: tb/tb_vcfg_unit.sv
// Directed self-checking bench for vcfg_unit (VLEN=128, ELEN=32, XLEN=32);
// expected values are hand-computed from the vtype/VLMAX rules.
module tb_vcfg_unit;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_avl;
  logic [31:0] cfg_vtype;
  logic        cfg_rs1_x0;
  logic        cfg_rd_x0;
  logic [4:0]  cfg_rd_idx;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        vstart_wr_en;
  logic [31:0] vstart_in;
  logic        vstart_clr;
  logic [31:0] vl_out;
  logic [31:0] vtype_out;
  logic [31:0] vstart_out;
  logic [31:0] vlenb_out;

  int n_checks = 0;
  int n_pass   = 0;

  vcfg_unit #(.VLEN(128), .ELEN(32), .XLEN(32)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_mode     (cfg_mode),
    .cfg_avl      (cfg_avl),
    .cfg_vtype    (cfg_vtype),
    .cfg_rs1_x0   (cfg_rs1_x0),
    .cfg_rd_x0    (cfg_rd_x0),
    .cfg_rd_idx   (cfg_rd_idx),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .vstart_wr_en (vstart_wr_en),
    .vstart_in    (vstart_in),
    .vstart_clr   (vstart_clr),
    .vl_out       (vl_out),
    .vtype_out    (vtype_out),
    .vstart_out   (vstart_out),
    .vlenb_out    (vlenb_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] mode, input logic [31:0] avl, input logic [31:0] vt,
                         input logic rs1x0, input logic rdx0, input logic [4:0] rd);
    cfg_valid  = 1'b1;
    cfg_mode   = mode;
    cfg_avl    = avl;
    cfg_vtype  = vt;
    cfg_rs1_x0 = rs1x0;
    cfg_rd_x0  = rdx0;
    cfg_rd_idx = rd;
  endtask

  // Inputs after the handshake must not matter
  task automatic scramble_req();
    cfg_mode   = 2'd3;
    cfg_avl    = 32'hFFFF_FFFF;
    cfg_vtype  = 32'h0000_0100;
    cfg_rs1_x0 = ~cfg_rs1_x0;
    cfg_rd_x0  = ~cfg_rd_x0;
    cfg_rd_idx = 5'd31;
  endtask

  task automatic run_req(input string tag, input logic [1:0] mode, input logic [31:0] avl,
                         input logic [31:0] vt, input logic rs1x0, input logic rdx0,
                         input logic [4:0] rd, input logic [31:0] exp_vl,
                         input logic [31:0] exp_vtype, input logic exp_wb);
    set_req(mode, avl, vt, rs1x0, rdx0, rd);
    check_eq({tag, "_rdy_idle"}, {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
    scramble_req();
    check_eq({tag, "_rdy_exec"}, {31'd0, cfg_ready}, 32'd0);
    check_eq({tag, "_wb_early"}, {31'd0, wb_valid}, 32'd0);
    tick();
    check_eq({tag, "_wb"}, {31'd0, wb_valid}, {31'd0, exp_wb});
    if (exp_wb) begin
      check_eq({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
      check_eq({tag, "_wb_data"}, wb_data, exp_vl);
    end
    check_eq({tag, "_vl"}, vl_out, exp_vl);
    check_eq({tag, "_vtype"}, vtype_out, exp_vtype);
    tick();
    check_eq({tag, "_wb_drop"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    nrst         = 1'b0;
    cfg_valid    = 1'b0;
    cfg_mode     = 2'd0;
    cfg_avl      = 32'd0;
    cfg_vtype    = 32'd0;
    cfg_rs1_x0   = 1'b0;
    cfg_rd_x0    = 1'b0;
    cfg_rd_idx   = 5'd0;
    vstart_wr_en = 1'b0;
    vstart_in    = 32'd0;
    vstart_clr   = 1'b0;
    repeat (3) tick();
    check_eq("rst_vl", vl_out, 32'd0);
    check_eq("rst_vtype", vtype_out, 32'h8000_0000);
    check_eq("rst_vstart", vstart_out, 32'd0);
    check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    check_eq("rst_ready", {31'd0, cfg_ready}, 32'd1);
    check_eq("vlenb", vlenb_out, 32'd16);
    nrst = 1'b1;
    tick();
    check_eq("idle_ready", {31'd0, cfg_ready}, 32'd1);

    // Basic legal configurations
    run_req("t1_sew32",   2'd0, 32'd10,  32'h010, 1'b0, 1'b0, 5'd5, 32'd4,   32'h010, 1'b1);
    run_req("t2_ivli",    2'd1, 32'd3,   32'h001, 1'b0, 1'b0, 5'd2, 32'd3,   32'h001, 1'b1);
    run_req("t2_vlmax32", 2'd0, 32'd100, 32'h001, 1'b0, 1'b0, 5'd2, 32'd32,  32'h001, 1'b1);
    run_req("t3_avl_max", 2'd2, 32'd5,   32'h00F, 1'b1, 1'b0, 5'd1, 32'd4,   32'h00F, 1'b1);
    run_req("t3_keep_vl", 2'd2, 32'd0,   32'h000, 1'b1, 1'b1, 5'd0, 32'd4,   32'h000, 1'b0);

    // Illegal vtypes and the reserved mode
    run_req("t4_sew64",   2'd0, 32'd10,  32'h018, 1'b0, 1'b0, 5'd3, 32'd0,   32'h8000_0000, 1'b1);
    run_req("t4_lmul4",   2'd0, 32'd10,  32'h004, 1'b0, 1'b0, 5'd3, 32'd0,   32'h8000_0000, 1'b1);
    run_req("t4_frac",    2'd0, 32'd10,  32'h015, 1'b0, 1'b0, 5'd3, 32'd0,   32'h8000_0000, 1'b1);
    run_req("t4_rsvd",    2'd0, 32'd10,  32'h100, 1'b0, 1'b0, 5'd3, 32'd0,   32'h8000_0000, 1'b1);
    run_req("t4_mode3",   2'd3, 32'd10,  32'h010, 1'b0, 1'b0, 5'd3, 32'd0,   32'h8000_0000, 1'b1);
    run_req("t4_ta_ma",   2'd0, 32'd2,   32'h0D0, 1'b0, 1'b0, 5'd8, 32'd2,   32'h0D0, 1'b1);
    run_req("t4_lmul8",   2'd0, 32'd200, 32'h003, 1'b0, 1'b0, 5'd9, 32'd128, 32'h003, 1'b1);

    // Valid held across three requests: the third (rs1=rd=x0) must see the second vl
    set_req(2'd0, 32'd6, 32'h008, 1'b0, 1'b0, 5'd7);
    check_eq("bb_rdy0", {31'd0, cfg_ready}, 32'd1);
    tick();
    set_req(2'd0, 32'd20, 32'h00F, 1'b0, 1'b0, 5'd9);
    check_eq("bb_rdy1", {31'd0, cfg_ready}, 32'd0);
    tick();
    check_eq("bb_rdy2", {31'd0, cfg_ready}, 32'd1);
    check_eq("bb_wb_a", {31'd0, wb_valid}, 32'd1);
    check_eq("bb_wb_rd_a", {27'd0, wb_rd}, 32'd7);
    check_eq("bb_wb_data_a", wb_data, 32'd6);
    tick();
    set_req(2'd2, 32'd0, 32'h008, 1'b1, 1'b1, 5'd0);
    check_eq("bb_rdy3", {31'd0, cfg_ready}, 32'd0);
    check_eq("bb_wb_gap", {31'd0, wb_valid}, 32'd0);
    tick();
    check_eq("bb_wb_b", {31'd0, wb_valid}, 32'd1);
    check_eq("bb_wb_rd_b", {27'd0, wb_rd}, 32'd9);
    check_eq("bb_wb_data_b", wb_data, 32'd4);
    check_eq("bb_vl_b", vl_out, 32'd4);
    tick();
    cfg_valid = 1'b0;
    tick();
    check_eq("bb_wb_c", {31'd0, wb_valid}, 32'd0);
    check_eq("bb_vl_c", vl_out, 32'd4);
    check_eq("bb_vtype_c", vtype_out, 32'h008);

    // vstart write, clear by commit, write beating commit, explicit clear
    vstart_wr_en = 1'b1;
    vstart_in    = 32'd7;
    tick();
    vstart_wr_en = 1'b0;
    check_eq("vs_wr7", vstart_out, 32'd7);
    run_req("vs_commit", 2'd0, 32'd10, 32'h010, 1'b0, 1'b0, 5'd5, 32'd4, 32'h010, 1'b1);
    check_eq("vs_commit_clr", vstart_out, 32'd0);
    set_req(2'd0, 32'd3, 32'h008, 1'b0, 1'b0, 5'd4);
    tick();
    cfg_valid    = 1'b0;
    vstart_wr_en = 1'b1;
    vstart_in    = 32'd9;
    tick();
    vstart_wr_en = 1'b0;
    check_eq("vs_wr_wins", vstart_out, 32'd9);
    check_eq("vs_vl", vl_out, 32'd3);
    check_eq("vs_wb_data", wb_data, 32'd3);
    vstart_clr = 1'b1;
    tick();
    vstart_clr = 1'b0;
    check_eq("vs_clr", vstart_out, 32'd0);

    // Reset landing in EXEC drops the request
    vstart_wr_en = 1'b1;
    vstart_in    = 32'd5;
    tick();
    vstart_wr_en = 1'b0;
    check_eq("rx_vstart5", vstart_out, 32'd5);
    set_req(2'd0, 32'd2, 32'h010, 1'b0, 1'b0, 5'd6);
    tick();
    cfg_valid = 1'b0;
    nrst      = 1'b0;
    tick();
    check_eq("rx_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("rx_vl", vl_out, 32'd0);
    check_eq("rx_vtype", vtype_out, 32'h8000_0000);
    check_eq("rx_vstart", vstart_out, 32'd0);
    check_eq("rx_wb_rd", {27'd0, wb_rd}, 32'd0);
    check_eq("rx_ready", {31'd0, cfg_ready}, 32'd1);
    nrst = 1'b1;
    tick();
    check_eq("rx_wb_after", {31'd0, wb_valid}, 32'd0);
    check_eq("rx_vl_after", vl_out, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
